// File: rtl/crack_pkg.sv
// rtl/crack_pkg.sv - state encoding, LED codes and BRAM address constants for crack_sequencer
package crack_pkg;

  // Externally visible state code
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECRYPT = 3'd1,
    ST_DICT    = 3'd2,
    ST_SUCCESS = 3'd3,
    ST_FAIL    = 3'd4
  } crack_state_e;

  // Internal sequencing steps; several steps share one visible state code
  typedef enum logic [3:0] {
    F_IDLE,
    F_RD_HASH,
    F_RD_KEY,
    F_RD_PT,
    F_DEC_WAIT,
    F_DICT_RD,
    F_DICT_WAIT,
    F_SUCCESS,
    F_FAIL
  } fsm_e;

  localparam logic [2:0] LED_RESET   = 3'b000;
  localparam logic [2:0] LED_IDLE    = 3'b011;
  localparam logic [2:0] LED_BUSY    = 3'b100;
  localparam logic [2:0] LED_SUCCESS = 3'b010;
  localparam logic [2:0] LED_FAIL    = 3'b001;

  localparam logic [7:0] HASH_ADDR = 8'd0;
  localparam logic [7:0] KEY_ADDR  = 8'd1;
  localparam logic [7:0] PT_ADDR   = 8'd2;

  function automatic crack_state_e state_of(input fsm_e f);
    crack_state_e s;
    case (f)
      F_IDLE:                                   s = ST_IDLE;
      F_RD_HASH, F_RD_KEY, F_RD_PT, F_DEC_WAIT: s = ST_DECRYPT;
      F_DICT_RD, F_DICT_WAIT:                   s = ST_DICT;
      F_SUCCESS:                                s = ST_SUCCESS;
      F_FAIL:                                   s = ST_FAIL;
      default:                                  s = ST_IDLE;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] led_of(input crack_state_e s);
    logic [2:0] l;
    case (s)
      ST_IDLE:             l = LED_IDLE;
      ST_DECRYPT, ST_DICT: l = LED_BUSY;
      ST_SUCCESS:          l = LED_SUCCESS;
      ST_FAIL:             l = LED_FAIL;
      default:             l = LED_RESET;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/aes_req_ctrl.sv
// rtl/aes_req_ctrl.sv - single-outstanding AES request pulse, done qualification and timeout
module aes_req_ctrl #(
  parameter int AES_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic abort,
  input  logic req,
  input  logic aes_done,
  output logic aes_start,
  output logic done_acc,
  output logic timed_out
);

  localparam int CW = $clog2(AES_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(AES_TIMEOUT);

  logic          start_q;
  logic          busy_q;
  logic [CW-1:0] cnt_q;

  // A done in the very cycle of the start pulse cannot belong to this request
  assign done_acc  = busy_q && aes_done && !start_q;
  assign timed_out = busy_q && !done_acc && (cnt_q == TMO);
  assign aes_start = start_q;

  // Launch pulse, outstanding flag and cycles elapsed since the pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (abort) begin
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      start_q <= req && !busy_q;
      if (req && !busy_q) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
      end else if (busy_q) begin
        if (done_acc || timed_out) busy_q <= 1'b0;
        else                       cnt_q  <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/crack_sequencer.sv
// rtl/crack_sequencer.sv - reads hash/key/plaintext from BRAM, then tries decrypt and a dictionary
module crack_sequencer #(
  parameter int DICT_START  = 3,
  parameter int DICT_SIZE   = 4,
  parameter int MEM_LAT     = 2,
  parameter int AES_TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  output logic         bram_en,
  output logic [7:0]   bram_addr,
  input  logic [127:0] bram_dout,
  output logic [127:0] aes_data,
  output logic [127:0] aes_key,
  output logic         aes_decrypt,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_out,
  output logic [2:0]   state,
  output logic [2:0]   led,
  output logic [7:0]   found_addr,
  output logic         timeout
);
  import crack_pkg::*;

  if (DICT_START < 3 || DICT_START + DICT_SIZE > 256) begin : g_bad_dict
    $error("crack_sequencer: dictionary range outside 3..255");
  end
  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("crack_sequencer: MEM_LAT must be 1..4");
  end

  localparam logic [2:0] LAT        = 3'(MEM_LAT);
  localparam logic [8:0] DICT_FIRST = 9'(DICT_START);
  localparam logic [8:0] DICT_END   = 9'(DICT_START + DICT_SIZE);
  localparam bit         DICT_EMPTY = (DICT_SIZE == 0);

  fsm_e         fsm_q, fsm_d;
  logic [127:0] hash_q, hash_d, key_q, key_d, pt_q, pt_d;
  logic [127:0] aes_data_q, aes_data_d, aes_key_q, aes_key_d;
  logic         aes_dec_q, aes_dec_d;
  logic [8:0]   idx_q, idx_d;
  logic [2:0]   rd_cnt_q, rd_cnt_d;
  logic [7:0]   found_q, found_d;
  logic         timeout_q, timeout_d;
  logic [2:0]   led_q;
  logic         aes_req, aes_acc, aes_tmo;
  logic         rd_done;
  logic         in_read;

  assign rd_done     = (rd_cnt_q == LAT);
  assign in_read     = (fsm_q == F_RD_HASH) || (fsm_q == F_RD_KEY) ||
                       (fsm_q == F_RD_PT)   || (fsm_q == F_DICT_RD);
  assign bram_en     = in_read && !rd_done;
  assign state       = state_of(fsm_q);
  assign led         = led_q;
  assign aes_data    = aes_data_q;
  assign aes_key     = aes_key_q;
  assign aes_decrypt = aes_dec_q;
  assign found_addr  = found_q;
  assign timeout     = timeout_q;

  aes_req_ctrl #(.AES_TIMEOUT(AES_TIMEOUT)) u_req (
    .clk       (clk),
    .reset     (reset),
    .abort     (abort),
    .req       (aes_req),
    .aes_done  (aes_done),
    .aes_start (aes_start),
    .done_acc  (aes_acc),
    .timed_out (aes_tmo)
  );

  // Address of the word currently being read
  always_comb begin
    bram_addr = '0;
    case (fsm_q)
      F_RD_HASH: bram_addr = HASH_ADDR;
      F_RD_KEY:  bram_addr = KEY_ADDR;
      F_RD_PT:   bram_addr = PT_ADDR;
      F_DICT_RD: bram_addr = idx_q[7:0];
      default:   bram_addr = '0;
    endcase
  end

  // Next-state and datapath updates; abort overrides everything else
  always_comb begin
    fsm_d      = fsm_q;
    hash_d     = hash_q;
    key_d      = key_q;
    pt_d       = pt_q;
    aes_data_d = aes_data_q;
    aes_key_d  = aes_key_q;
    aes_dec_d  = aes_dec_q;
    idx_d      = idx_q;
    rd_cnt_d   = rd_cnt_q;
    found_d    = found_q;
    timeout_d  = timeout_q;
    aes_req    = 1'b0;
    case (fsm_q)
      F_IDLE: begin
        if (start) begin
          fsm_d    = F_RD_HASH;
          rd_cnt_d = '0;
        end
      end
      F_RD_HASH: begin
        if (rd_done) begin
          hash_d   = bram_dout;
          rd_cnt_d = '0;
          fsm_d    = F_RD_KEY;
        end else rd_cnt_d = rd_cnt_q + 3'd1;
      end
      F_RD_KEY: begin
        if (rd_done) begin
          key_d    = bram_dout;
          rd_cnt_d = '0;
          fsm_d    = F_RD_PT;
        end else rd_cnt_d = rd_cnt_q + 3'd1;
      end
      F_RD_PT: begin
        if (rd_done) begin
          pt_d       = bram_dout;
          rd_cnt_d   = '0;
          aes_req    = 1'b1;
          aes_data_d = hash_q;
          aes_key_d  = key_q;
          aes_dec_d  = 1'b1;
          fsm_d      = F_DEC_WAIT;
        end else rd_cnt_d = rd_cnt_q + 3'd1;
      end
      F_DEC_WAIT: begin
        if (aes_tmo) begin
          timeout_d = 1'b1;
          fsm_d     = F_FAIL;
        end else if (aes_acc) begin
          if (aes_out == pt_q) begin
            found_d = PT_ADDR;
            fsm_d   = F_SUCCESS;
          end else if (DICT_EMPTY) begin
            fsm_d = F_FAIL;
          end else begin
            idx_d = DICT_FIRST;
            fsm_d = F_DICT_RD;
          end
        end
      end
      F_DICT_RD: begin
        if (rd_done) begin
          rd_cnt_d   = '0;
          aes_req    = 1'b1;
          aes_data_d = bram_dout;
          aes_key_d  = key_q;
          aes_dec_d  = 1'b0;
          fsm_d      = F_DICT_WAIT;
        end else rd_cnt_d = rd_cnt_q + 3'd1;
      end
      F_DICT_WAIT: begin
        if (aes_tmo) begin
          timeout_d = 1'b1;
          fsm_d     = F_FAIL;
        end else if (aes_acc) begin
          if (aes_out == hash_q) begin
            found_d = idx_q[7:0];
            fsm_d   = F_SUCCESS;
          end else if (idx_q + 9'd1 == DICT_END) begin
            fsm_d = F_FAIL;
          end else begin
            idx_d = idx_q + 9'd1;
            fsm_d = F_DICT_RD;
          end
        end
      end
      F_SUCCESS, F_FAIL: fsm_d = fsm_q;
      default:           fsm_d = F_IDLE;
    endcase
    if (abort) begin
      fsm_d     = F_IDLE;
      rd_cnt_d  = '0;
      idx_d     = '0;
      found_d   = '0;
      timeout_d = 1'b0;
      aes_req   = 1'b0;
    end
  end

  // State, captured words, AES operand registers and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q      <= F_IDLE;
      hash_q     <= '0;
      key_q      <= '0;
      pt_q       <= '0;
      aes_data_q <= '0;
      aes_key_q  <= '0;
      aes_dec_q  <= 1'b1;
      idx_q      <= '0;
      rd_cnt_q   <= '0;
      found_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      hash_q     <= hash_d;
      key_q      <= key_d;
      pt_q       <= pt_d;
      aes_data_q <= aes_data_d;
      aes_key_q  <= aes_key_d;
      aes_dec_q  <= aes_dec_d;
      idx_q      <= idx_d;
      rd_cnt_q   <= rd_cnt_d;
      found_q    <= found_d;
      timeout_q  <= timeout_d;
    end
  end

  // Status LED follows the visible state one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) led_q <= LED_RESET;
    else        led_q <= led_of(state_of(fsm_q));
  end

endmodule

// File: doc/crack_sequencer.md
CRACK_SEQUENCER -- requirements
Module: crack_sequencer

Interface
REQ-001 Parameter: DICT_START, 3, first dictionary word address in SD_SIM.
REQ-002 Parameter: DICT_SIZE, 4, number of dictionary words; 0 is legal.
REQ-003 Parameter: MEM_LAT, 2, BRAM read latency in cycles (1..4).
REQ-004 Parameter: AES_TIMEOUT, 1024, max cycles from aes_start to aes_done.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset, with these ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle request to begin cracking
- abort  in  1  one-cycle request to return to IDLE
- bram_en  out  1  BRAM read enable
- bram_addr  out  8  BRAM address
- bram_dout  in  128  BRAM read data, valid MEM_LAT cycles after address
- aes_data  out  128  encrypter data input
- aes_key  out  128  encrypter key input
- aes_decrypt  out  1  1 = decrypt, 0 = encrypt
- aes_start  out  1  one-cycle operation request
- aes_done  in  1  one-cycle completion strobe
- aes_out  in  128  encrypter result, valid while aes_done = 1
- state  out  3  0 IDLE, 1 DECRYPT, 2 DICT, 3 SUCCESS, 4 FAIL
- led  out  3  RGB status
- found_addr  out  8  address of the matching word
- timeout  out  1  sticky AES timeout flag

Function
REQ-006 On start in IDLE, the block SHALL read mem[0] into H (hashed password), mem[1] into K (key) and mem[2] into P (known plaintext), one address at a time. Each read takes MEM_LAT cycles, and bram_en SHALL be high only during the read.
REQ-007 DECRYPT SHALL issue aes_decrypt=1, aes_data=H, aes_key=K. If aes_out == P, the block SHALL set found_addr=2 and go to SUCCESS; otherwise it SHALL go to DICT.
REQ-008 DICT SHALL process addresses i = DICT_START to DICT_START+DICT_SIZE-1 in order. For each i it SHALL read mem[i], then issue aes_decrypt=0, aes_data=mem[i], aes_key=K. If aes_out == H, it SHALL set found_addr=i and go to SUCCESS.
REQ-009 After the last word mismatches, or immediately when DICT_SIZE=0, the block SHALL go to FAIL. The index counter SHALL be 9 bits so that it never wraps.
REQ-010 aes_start SHALL be a single-cycle pulse. aes_data, aes_key and aes_decrypt SHALL stay stable from the pulse until aes_done. Only one operation SHALL be outstanding at a time.
REQ-011 aes_done SHALL be ignored unless an operation is outstanding. aes_done in the same cycle as aes_start SHALL NOT be accepted.
REQ-012 If aes_done does not arrive within AES_TIMEOUT cycles, the block SHALL set timeout=1 and go to FAIL.
REQ-013 SUCCESS and FAIL SHALL hold until abort or reset. start SHALL be ignored outside IDLE.
REQ-014 abort SHALL return the block to IDLE from any state within 1 cycle. It SHALL drop aes_start and bram_en, clear timeout, and clear found_addr. A late aes_done after abort SHALL be ignored.
REQ-015 If start and abort are asserted in the same cycle, abort SHALL win.
REQ-016 led SHALL be registered from state: IDLE 3'b011, DECRYPT/DICT 3'b100, SUCCESS 3'b010, FAIL 3'b001.
REQ-017 Elaboration SHALL fail if DICT_START < 3 or DICT_START+DICT_SIZE > 256.

Reset
REQ-018 While reset=0, the outputs SHALL be: state=0, led=3'b000, bram_en=0, bram_addr=0, aes_start=0, aes_decrypt=1, aes_data=0, aes_key=0, found_addr=0, timeout=0. H, K, P and all counters SHALL be cleared.
REQ-019 Reset asserted mid-operation SHALL take effect immediately. After reset deasserts, led SHALL become 3'b011 on the first clk edge.

Structure
REQ-020 Package crack_pkg SHALL hold the state encoding, the LED codes, and the address constants HASH_ADDR=0, KEY_ADDR=1, PT_ADDR=2.
REQ-021 The sub-module aes_req_ctrl SHALL own the aes_start pulse, the outstanding flag and the timeout counter.

Verification
The bench SHALL use an encrypter model with out = data XOR key and a latency of 10 cycles.
REQ-022 Test 1: H=K^P -> DECRYPT match; SUCCESS with found_addr=2 and led=3'b010; no DICT reads occur.
REQ-023 Test 2: H=mem[5]^K (DICT_START=3) -> encrypt calls for addresses 3, 4, 5 only; SUCCESS with found_addr=5.
REQ-024 Test 3: no match with DICT_SIZE=4 -> exactly 5 aes_start pulses (1 decrypt + 4 encrypt); FAIL with led=3'b001.
REQ-025 Test 4: model never returns aes_done -> after AES_TIMEOUT cycles, timeout=1 and state=4; abort -> state=0 and timeout=0.
REQ-026 Test 5: abort during the DICT AES wait, with aes_done arriving 3 cycles later -> state stays 0 and the late done is ignored; a new start runs the full sequence cleanly.
REQ-027 Test 6: reset pulsed low mid-DICT -> all outputs reach the REQ-018 values asynchronously; start+abort in the same cycle -> remains IDLE.
